lfsr_stream_checker: RTL
========================

// Module: lfsr_stream_checker
// PURPOSE
//  NoC sink endpoint: the receiving end of a num_gen LFSR packet stream on an AXI-Stream mesh port.
//  - Regenerates the expected LFSR sequence locally and checks every received beat and its TLAST.
//  - Counts mismatches, then sends one status packet back into the mesh.
//  - Raises DONE/PASS.
// PARAMETERS
//  TDATAW        32     stream data width (>=32)
//  TDESTW        4      stream dest width
//  LFSR_DW       8      LFSR width (<=16)
//  LFSR_DEFAULT  8'h01  LFSR seed; must equal the transmitting num_gen seed
//  NUM_PACKETS   16     beats per checked packet (>=1)
//  RESP_TDEST    4'd3   mesh destination of the status packet
//  TIMEOUT_CYC   1024   idle watchdog limit (used only with LFSR_CHK_TIMEOUT_EN)
// PORTS
//  CLK            in   1       single clock
//  RST            in   1       async reset, active-high
//  START          in   1       1-cycle arm pulse
//  AXIS_S_TVALID  in   1       mesh->checker valid
//  AXIS_S_TREADY  out  1       checker ready
//  AXIS_S_TDATA   in   TDATAW  received word
//  AXIS_S_TLAST   in   1       end of packet
//  AXIS_S_TDEST   in   TDESTW  ignored
//  AXIS_M_TVALID  out  1       status packet valid
//  AXIS_M_TREADY  in   1       mesh ready
//  AXIS_M_TDATA   out  TDATAW  status word
//  AXIS_M_TLAST   out  1       always 1 with TVALID
//  AXIS_M_TDEST   out  TDESTW  = RESP_TDEST
//  RX_CNT         out  16      beats accepted this run
//  ERR_CNT        out  16      mismatches this run, saturating at 16'hFFFF
//  DONE           out  1       run finished, status delivered
//  PASS           out  1       DONE && ERR_CNT==0 && !TIMEOUT
//  TIMEOUT        out  1       watchdog fired
// BEHAVIOUR
//  Reset: FSM=IDLE; all outputs and counters 0; lfsr=LFSR_DEFAULT. Reset mid-run aborts immediately.
//  LFSR: Fibonacci, shift left, fb = q[7]^q[5]^q[4]^q[3] (x^8+x^6+x^5+x^4+1), fb into bit 0.
//   Expected word = zero-extended lfsr. First expected word = seed.
//  FSM:
//   IDLE: TREADY=0. On START: clear counters and flags, lfsr<=seed, go RECV.
//   RECV: TREADY=1. START is ignored.
//    - Each beat (TVALID&TREADY): RX_CNT+1; lfsr advances regardless of match.
//    - Each beat adds at most +1 to ERR_CNT, if TDATA!=expected OR TLAST!=(beat==NUM_PACKETS).
//    - Beat NUM_PACKETS -> REPORT.
//   REPORT: TREADY=0. M_TVALID=1 from the cycle after the final beat.
//    - Status word: [31:24]=8'hA5, [23]=TIMEOUT, [22:16]=0, [15:0]=ERR_CNT; upper bits above 31 = 0.
//    - TDATA/TLAST/TDEST held stable until M_TREADY. On handshake -> DONE.
//   DONE: DONE=1 and PASS valid from the cycle after the handshake; held.
//    - START -> clear and re-arm into RECV; DONE/PASS drop the same edge.
//  Beats arriving in IDLE/REPORT/DONE are back-pressured, never dropped.
//  Counters are unsigned 16-bit. ERR_CNT saturates. RX_CNT cannot exceed NUM_PACKETS.
// CONFIGURATION
//  LFSR_CHK_TIMEOUT_EN defined:
//   - In RECV a 16-bit idle counter increments each cycle with no accepted beat; cleared on a beat.
//   - At TIMEOUT_CYC: TIMEOUT<=1, go REPORT with status bit23=1. Missing beats are not added to ERR_CNT.
//  Not defined: no watchdog; TIMEOUT tied 0; RECV waits indefinitely.
// TESTING
//  1 START, 16 correct beats from seed 8'h01, TLAST on beat 16 -> status 32'hA5000000 to tdest 3; DONE=1, PASS=1.
//  2 Beat 5 data XOR 1 -> ERR_CNT=1, status 32'hA5000001, PASS=0; later beats still match (lfsr advanced).
//  3 TLAST on beat 8, absent on beat 16 -> ERR_CNT=2, status 32'hA5000002.
//  4 M_TREADY low 10 cycles in REPORT -> TVALID/TDATA/TLAST stable all 10 cycles; DONE rises 1 cycle after handshake.
//  5 RST pulse after 7 beats -> all outputs 0, S_TREADY=0; new START plus 16 correct beats -> PASS=1.
//  6 (EN, TIMEOUT_CYC=64) stop after 3 beats -> status sent 64 cycles after beat 3, 32'hA5800000; TIMEOUT=1, RX_CNT=3, PASS=0.

Source files
------------

// File: rtl/lfsr_stream_checker.sv
// LFSR stream sink: regenerates the num_gen sequence, checks each beat and TLAST, then returns one status word.
// Optional idle watchdog is compiled in with LFSR_CHK_TIMEOUT_EN.
module lfsr_stream_checker #(
    parameter int                  TDATAW       = 32,
    parameter int                  TDESTW       = 4,
    parameter int                  LFSR_DW      = 8,
    parameter logic [LFSR_DW-1:0]  LFSR_DEFAULT = 'h01,
    parameter int                  NUM_PACKETS  = 16,
    parameter logic [TDESTW-1:0]   RESP_TDEST   = 'd3,
    parameter int                  TIMEOUT_CYC  = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_axis_s_tvalid,
    output logic              o_axis_s_tready,
    input  logic [TDATAW-1:0] i_axis_s_tdata,
    input  logic              i_axis_s_tlast,
    input  logic [TDESTW-1:0] i_axis_s_tdest,
    output logic              o_axis_m_tvalid,
    input  logic              i_axis_m_tready,
    output logic [TDATAW-1:0] o_axis_m_tdata,
    output logic              o_axis_m_tlast,
    output logic [TDESTW-1:0] o_axis_m_tdest,
    output logic [15:0]       o_rx_cnt,
    output logic [15:0]       o_err_cnt,
    output logic              o_done,
    output logic              o_pass,
    output logic              o_timeout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RECV   = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Maximal-length Fibonacci taps per width; width 8 gives x^8+x^6+x^5+x^4+1.
    function automatic logic [15:0] tap_mask(input int w);
        case (w)
            2:       return 16'h0003;
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h00B8;
        endcase
    endfunction

    localparam logic [15:0]        TAPS_FULL = tap_mask(LFSR_DW);
    localparam logic [LFSR_DW-1:0] TAPS      = TAPS_FULL[LFSR_DW-1:0];
    localparam logic [15:0]        LAST_IDX  = 16'(NUM_PACKETS - 1);

    logic [1:0]         r_state;
    logic [LFSR_DW-1:0] r_lfsr;
    logic [15:0]        r_rx_cnt;
    logic [15:0]        r_err_cnt;
    logic               r_timeout;

    logic               w_beat;
    logic               w_final;
    logic               w_mismatch;
    logic               w_fb;
    logic [LFSR_DW-1:0] w_lfsr_nxt;
    logic [TDATAW-1:0]  w_expected;
    logic [TDATAW-1:0]  w_status;
    logic               w_idle_expired;
    logic               w_unused_ok;

    assign o_axis_s_tready = (r_state == S_RECV);
    assign w_beat          = i_axis_s_tvalid && o_axis_s_tready;
    assign w_final         = (r_rx_cnt == LAST_IDX);

    assign w_fb       = ^(r_lfsr & TAPS);
    assign w_lfsr_nxt = {r_lfsr[LFSR_DW-2:0], w_fb};

    always_comb begin
        w_expected                = '0;
        w_expected[LFSR_DW-1:0]   = r_lfsr;
    end

    // A bad word and a misplaced TLAST on the same beat still count as one error.
    assign w_mismatch = (i_axis_s_tdata != w_expected) || (i_axis_s_tlast != w_final);

    always_comb begin
        w_status        = '0;
        w_status[31:0]  = {8'hA5, r_timeout, 7'd0, r_err_cnt};
    end

`ifdef LFSR_CHK_TIMEOUT_EN
    logic [15:0] r_idle_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idle_cnt <= '0;
        end else if ((r_state != S_RECV) || w_beat) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    // Fires on the edge where the idle count would reach TIMEOUT_CYC.
    assign w_idle_expired = (r_state == S_RECV) && !w_beat &&
                            (({1'b0, r_idle_cnt} + 17'd1) == 17'(TIMEOUT_CYC));
    assign w_unused_ok    = ^i_axis_s_tdest;
`else
    logic [15:0] w_unused_timeout;

    assign w_unused_timeout = 16'(TIMEOUT_CYC);
    assign w_idle_expired   = 1'b0;
    assign w_unused_ok      = ^i_axis_s_tdest;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_lfsr    <= LFSR_DEFAULT;
            r_rx_cnt  <= '0;
            r_err_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state   <= S_RECV;
                        r_lfsr    <= LFSR_DEFAULT;
                        r_rx_cnt  <= '0;
                        r_err_cnt <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                S_RECV: begin
                    if (w_beat) begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                        r_lfsr   <= w_lfsr_nxt;
                        if (w_mismatch && (r_err_cnt != 16'hFFFF)) begin
                            r_err_cnt <= r_err_cnt + 16'd1;
                        end
                        if (w_final) begin
                            r_state <= S_REPORT;
                        end
                    end else if (w_idle_expired) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (i_axis_m_tready) begin
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Master side is gated by TVALID so every output reads zero outside REPORT.
    assign o_axis_m_tvalid = (r_state == S_REPORT);
    assign o_axis_m_tdata  = o_axis_m_tvalid ? w_status : '0;
    assign o_axis_m_tlast  = o_axis_m_tvalid;
    assign o_axis_m_tdest  = o_axis_m_tvalid ? RESP_TDEST : '0;

    assign o_rx_cnt  = r_rx_cnt;
    assign o_err_cnt = r_err_cnt;
    assign o_done    = (r_state == S_DONE);
    assign o_pass    = o_done && (r_err_cnt == 16'd0) && !r_timeout;
    assign o_timeout = r_timeout;

endmodule
